// File: rtl/uart_frame_rx_if.sv
// Write-side bundle of uart_frame_rx: received byte, buffer write strobe/address and status pulses.
interface uart_frame_rx_if;
    logic [7:0]  o_Byte;
    logic        o_Wr_En;
    logic [13:0] o_Wr_Addr;
    logic        o_Frame_Done;
    logic        o_Frame_Err;
    logic        o_Timeout;

    modport master (
        output o_Byte,
        output o_Wr_En,
        output o_Wr_Addr,
        output o_Frame_Done,
        output o_Frame_Err,
        output o_Timeout
    );

    modport slave (
        input o_Byte,
        input o_Wr_En,
        input o_Wr_Addr,
        input o_Frame_Done,
        input o_Frame_Err,
        input o_Timeout
    );
endinterface

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that writes bytes into a frame buffer, resynced by a frame indicator.
// Define RX_TIMEOUT_EN to build the inter-byte gap timeout that abandons partial frames.
module uart_frame_rx #(
    parameter int CLKS_PER_BIT    = 1085,
    parameter int BYTES_PER_FRAME = 9216,
    parameter int TIMEOUT_CLKS    = 11935
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Rx,
    input  logic            i_Frame_Indicator,
    uart_frame_rx_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [13:0]      LAST_ADDR = 14'(BYTES_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             fi_meta_r;
    logic             fi_sync_r;
    logic             fi_prev_r;
    logic             fi_rise_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             pending_r;
    logic [13:0]      addr_r;
    logic [7:0]       byte_r;
    logic             wr_en_r;
    logic             frame_done_r;
    logic             frame_err_r;
    logic             timeout_hit_s;

    // Two-flop synchronizers; the line idles high so its flops reset to 1
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            fi_meta_r <= 1'b0;
            fi_sync_r <= 1'b0;
            fi_prev_r <= 1'b0;
        end else begin
            rx_meta_r <= i_Rx;
            rx_sync_r <= rx_meta_r;
            fi_meta_r <= i_Frame_Indicator;
            fi_sync_r <= fi_meta_r;
            fi_prev_r <= fi_sync_r;
        end
    end

    assign fi_rise_s = fi_sync_r & ~fi_prev_r;

`ifdef RX_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(TIMEOUT_CLKS);

    logic [GAP_W-1:0] gap_r;
    logic             timeout_r;

    assign timeout_hit_s = (gap_r == GAP_LIM);

    // Gap counter runs only while a partial frame sits idle; any start bit or write restarts it
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            gap_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_hit_s & ~fi_rise_s;
            if (fi_rise_s || (state_r != IDLE) || (addr_r == 14'd0) || pending_r ||
                wr_en_r || !rx_sync_r || timeout_hit_s) begin
                gap_r <= '0;
            end else begin
                gap_r <= gap_r + GAP_W'(1);
            end
        end
    end

    assign bus.o_Timeout = timeout_r;
`else
    assign timeout_hit_s = 1'b0;
    assign bus.o_Timeout = 1'b0;
`endif

    // Bit FSM, byte assembly, write strobe generation and buffer address
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            pending_r    <= 1'b0;
            addr_r       <= 14'd0;
            byte_r       <= 8'h00;
            wr_en_r      <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            wr_en_r      <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (fi_rise_s) begin
                // Frame resync beats any byte in flight, including one about to be written
                state_r   <= IDLE;
                cnt_r     <= '0;
                bit_idx_r <= 3'd0;
                pending_r <= 1'b0;
                addr_r    <= 14'd0;
            end else begin
                if (wr_en_r) begin
                    addr_r <= (addr_r == LAST_ADDR) ? 14'd0 : addr_r + 14'd1;
                end else if (timeout_hit_s) begin
                    addr_r <= 14'd0;
                end else begin
                    addr_r <= addr_r;
                end

                if (pending_r) begin
                    pending_r    <= 1'b0;
                    byte_r       <= shift_r;
                    wr_en_r      <= 1'b1;
                    frame_done_r <= (addr_r == LAST_ADDR);
                end else begin
                    pending_r <= 1'b0;
                end

                case (state_r)
                    IDLE: begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        if (!rx_sync_r) begin
                            state_r <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    START: begin
                        if (cnt_r == HALF_CNT) begin
                            cnt_r   <= '0;
                            state_r <= rx_sync_r ? IDLE : DATA;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_r == FULL_CNT) begin
                            cnt_r     <= '0;
                            shift_r   <= {rx_sync_r, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                            if (bit_idx_r == 3'd7) begin
                                state_r <= STOP;
                            end else begin
                                state_r <= DATA;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt_r == FULL_CNT) begin
                            cnt_r   <= '0;
                            state_r <= IDLE;
                            if (rx_sync_r) begin
                                pending_r <= 1'b1;
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_Byte       = byte_r;
    assign bus.o_Wr_En      = wr_en_r;
    assign bus.o_Wr_Addr    = addr_r;
    assign bus.o_Frame_Done = frame_done_r;
    assign bus.o_Frame_Err  = frame_err_r;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx; bit timing and timeout are scaled down to keep runs short.
module tb_uart_frame_rx;
    localparam int CPB     = 16;
    localparam int BPF     = 4;
    localparam int TO_CLKS = 176;

    typedef struct {
        logic [7:0]  data;
        logic [13:0] addr;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic fi  = 1'b0;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          err_seen  = 0;
    int          to_seen   = 0;
    exp_t        exp_q[$];
    exp_t        got_e;
    logic [13:0] exp_addr  = 14'd0;
    logic [3:0]  prev_strb = 4'b0000;
    logic [3:0]  cur_strb;

    uart_frame_rx_if bus ();

    uart_frame_rx #(
        .CLKS_PER_BIT   (CPB),
        .BYTES_PER_FRAME(BPF),
        .TIMEOUT_CLKS   (TO_CLKS)
    ) dut (
        .i_Clk            (clk),
        .i_Rst            (rst),
        .i_Rx             (rx),
        .i_Frame_Indicator(fi),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every write and counts status pulses
    always @(negedge clk) begin
        if (bus.o_Wr_En === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: byte=%h addr=%0d, expected no write", bus.o_Byte, bus.o_Wr_Addr);
            end else begin
                got_e = exp_q.pop_front();
                if ({bus.o_Byte, bus.o_Wr_Addr, bus.o_Frame_Done} !== {got_e.data, got_e.addr, got_e.done})
                    $display("FAIL write: got byte=%h addr=%0d done=%b, expected byte=%h addr=%0d done=%b",
                             bus.o_Byte, bus.o_Wr_Addr, bus.o_Frame_Done, got_e.data, got_e.addr, got_e.done);
                else
                    pass_cnt++;
            end
        end else if (bus.o_Frame_Done === 1'b1) begin
            total_cnt++;
            $display("FAIL done_without_write: o_Frame_Done=1 with o_Wr_En=0, expected 0");
        end
        if (bus.o_Frame_Err === 1'b1) err_seen++;
        if (bus.o_Timeout === 1'b1) to_seen++;
        cur_strb = {bus.o_Wr_En, bus.o_Frame_Done, bus.o_Frame_Err, bus.o_Timeout};
        if (cur_strb != 4'b0000) begin
            total_cnt++;
            if ((cur_strb & prev_strb) != 4'b0000)
                $display("FAIL strobe_width: strobes %b high two cycles in a row (prev %b), expected single pulses", cur_strb, prev_strb);
            else
                pass_cnt++;
        end
        prev_strb = cur_strb;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.addr = exp_addr;
        e.done = (exp_addr == 14'(BPF - 1));
        exp_q.push_back(e);
        exp_addr = (exp_addr == 14'(BPF - 1)) ? 14'd0 : exp_addr + 14'd1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        if (stop_bit) push_exp(d);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_frame_ind();
        fi = 1'b1;
        repeat (6) @(negedge clk);
        fi = 1'b0;
        repeat (6) @(negedge clk);
        exp_addr = 14'd0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        fi  = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus.o_Byte !== 8'h00) $display("FAIL reset_byte: got %h, expected 00", bus.o_Byte); else pass_cnt++;
        total_cnt++;
        if (bus.o_Wr_En !== 1'b0) $display("FAIL reset_wr_en: got %b, expected 0", bus.o_Wr_En); else pass_cnt++;
        total_cnt++;
        if (bus.o_Wr_Addr !== 14'd0) $display("FAIL reset_addr: got %0d, expected 0", bus.o_Wr_Addr); else pass_cnt++;
        total_cnt++;
        if ({bus.o_Frame_Done, bus.o_Frame_Err, bus.o_Timeout} !== 3'b000)
            $display("FAIL reset_pulses: got %b, expected 000", {bus.o_Frame_Done, bus.o_Frame_Err, bus.o_Timeout});
        else pass_cnt++;
        rst = 1'b0;
        idle(10);
        // Reset in the middle of a byte must abandon it cleanly
        rx = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.o_Byte, bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Frame_Err} !== 24'h0)
            $display("FAIL midbyte_reset: got byte=%h wr=%b addr=%0d err=%b, expected all 0",
                     bus.o_Byte, bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Frame_Err);
        else pass_cnt++;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(3 * CPB);
        total_cnt++;
        if (err_seen !== 0) $display("FAIL reset_no_err: got %0d error pulses, expected 0", err_seen); else pass_cnt++;
    endtask

    task automatic test_basic();
        send_byte(8'hA5, 1'b1);
        idle(CPB);
        send_byte(8'h5A, 1'b1);
        wait_drain();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL basic_drain: got %0d pending writes, expected 0", exp_q.size()); else pass_cnt++;
        idle(CPB);
    endtask

    task automatic test_glitch();
        int err_before;
        err_before = err_seen;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(3 * CPB);
        total_cnt++;
        if (err_seen - err_before !== 0) $display("FAIL glitch_err: got %0d error pulses, expected 0", err_seen - err_before); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int err_before;
        err_before = err_seen;
        send_byte(8'h3C, 1'b0);
        idle(3 * CPB);
        total_cnt++;
        if (err_seen - err_before !== 1) $display("FAIL stop_err_count: got %0d error pulses, expected 1", err_seen - err_before); else pass_cnt++;
        send_byte(8'h77, 1'b1);
        wait_drain();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL err_followup_drain: got %0d pending writes, expected 0", exp_q.size()); else pass_cnt++;
        idle(CPB);
    endtask

    task automatic test_frame_wrap();
        pulse_frame_ind();
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1);
            idle(CPB);
        end
        wait_drain();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL wrap_drain: got %0d pending writes, expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_resync();
        int err_before;
        logic [7:0] partial;
        partial = 8'h33;
        pulse_frame_ind();
        send_byte(8'h11, 1'b1);
        idle(CPB);
        send_byte(8'h22, 1'b1);
        idle(CPB);
        err_before = err_seen;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (CPB) @(negedge clk);
        end
        fi = 1'b1;
        rx = 1'b1;
        exp_addr = 14'd0;
        repeat (3 * CPB) @(negedge clk);
        fi = 1'b0;
        idle(CPB);
        send_byte(8'h44, 1'b1);
        wait_drain();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL resync_drain: got %0d pending writes, expected 0", exp_q.size()); else pass_cnt++;
        total_cnt++;
        if (err_seen - err_before !== 0) $display("FAIL resync_err: got %0d error pulses, expected 0", err_seen - err_before); else pass_cnt++;
        idle(CPB);
    endtask

    task automatic test_timeout();
        int to_before;
        int to_exp;
        pulse_frame_ind();
        send_byte(8'hC3, 1'b1);
        idle(CPB);
        send_byte(8'h3C, 1'b1);
        wait_drain();
        to_before = to_seen;
        idle(250);
`ifdef RX_TIMEOUT_EN
        to_exp   = 1;
        exp_addr = 14'd0;
`else
        to_exp   = 0;
`endif
        total_cnt++;
        if (to_seen - to_before !== to_exp) $display("FAIL timeout_count: got %0d pulses, expected %0d", to_seen - to_before, to_exp); else pass_cnt++;
        send_byte(8'h99, 1'b1);
        wait_drain();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL timeout_drain: got %0d pending writes, expected 0", exp_q.size()); else pass_cnt++;
        idle(CPB);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b1);
        idle(2);
        wait_drain();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL b2b_drain: got %0d pending writes, expected 0", exp_q.size()); else pass_cnt++;
        idle(2 * CPB);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_frame_wrap();
        test_resync();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1085, i_Clk cycles per UART bit (115200 baud at 125 MHz).
REQ-002 Parameter BYTES_PER_FRAME, default 9216, bytes per image frame.
REQ-003 Parameter TIMEOUT_CLKS, default 11935, maximum idle gap between bytes inside a frame (used only under RX_TIMEOUT_EN).
REQ-004 i_Clk  input  1  sole clock; all logic is on its rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 i_Rx  input  1  serial line, 8N1, LSB first, idles high; asynchronous to i_Clk.
REQ-007 i_Frame_Indicator  input  1  frame-boundary level from the transmitter side; asynchronous to i_Clk.
REQ-008 o_Byte  output  8  last received data byte.
REQ-009 o_Wr_En  output  1  one-cycle write strobe for o_Byte at o_Wr_Addr.
REQ-010 o_Wr_Addr  output  14  frame buffer write address, 0..BYTES_PER_FRAME-1.
REQ-011 o_Frame_Done  output  1  one-cycle pulse when the last byte of a frame is written.
REQ-012 o_Frame_Err  output  1  one-cycle pulse on a stop-bit error.
REQ-013 o_Timeout  output  1  one-cycle pulse on an inter-byte timeout (held 0 without RX_TIMEOUT_EN).

Function
REQ-014 i_Rx and i_Frame_Indicator each pass through a 2-flop synchronizer before use; all timing below is relative to the synchronized signals.
REQ-015 Bit FSM states: IDLE, START, DATA, STOP; a single bit-timing counter is shared by all states.
REQ-016 IDLE: a low on the synchronized i_Rx moves the FSM to START and clears the counter.
REQ-017 START: at count CLKS_PER_BIT/2 (integer division), the line is sampled; low -> DATA with the counter cleared; high -> false start, back to IDLE, no outputs pulsed.
REQ-018 DATA: the line is sampled every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first; after the 8th sample -> STOP.
REQ-019 STOP: the line is sampled CLKS_PER_BIT cycles after the last data sample; high -> byte accepted; low -> o_Frame_Err pulses, the byte is discarded, and the address is unchanged; either outcome -> IDLE.
REQ-020 Byte accepted: on the cycle after the stop sample, o_Byte is updated, o_Wr_En=1 for one cycle with o_Wr_Addr equal to the current address, and the address increments on the following edge.
REQ-021 Frame end: when the write is at address BYTES_PER_FRAME-1, o_Frame_Done pulses in the same cycle as o_Wr_En and the address wraps to 0.
REQ-022 Frame resync: a rising edge of the synchronized i_Frame_Indicator clears the address to 0 and aborts any byte in progress (FSM -> IDLE, no write, no error pulse).
REQ-023 Simultaneous frame-indicator rise and byte acceptance: the indicator wins; the write is suppressed and the address becomes 0.
REQ-024 o_Byte holds its value between writes; the strobe outputs are never high for more than one consecutive cycle.

Reset
REQ-025 i_Rst asserted, at any time including mid-byte: FSM=IDLE, counters=0, address=0, o_Byte=0, o_Wr_En=0, o_Frame_Done=0, o_Frame_Err=0, o_Timeout=0.
REQ-026 i_Rst asserted: the i_Rx synchronizer flops=1, the i_Frame_Indicator synchronizer flops and edge-detect flop=0.
REQ-027 After i_Rst deasserts, the block waits in IDLE for a start bit; no spurious start from the synchronizer reset values.

Configuration
REQ-028 Macro RX_TIMEOUT_EN defined: while the address is nonzero and the FSM is in IDLE, a gap counter runs. When it reaches TIMEOUT_CLKS, o_Timeout pulses and the address clears to 0. The gap counter clears on every start bit.
REQ-029 Macro RX_TIMEOUT_EN undefined: no gap counter is built; o_Timeout is tied 0; a partial frame persists until i_Frame_Indicator or reset.

Verification
REQ-030 Send byte 0xA5 with CLKS_PER_BIT=1085 after reset -> one o_Wr_En, o_Byte=0xA5, o_Wr_Addr=0; the next write is at address 1.
REQ-031 1-cycle-per-bit-short glitch (i_Rx low for 300 cycles) -> no o_Wr_En, no o_Frame_Err, FSM back in IDLE.
REQ-032 Byte 0x3C with the stop bit driven low -> o_Frame_Err single pulse, no o_Wr_En, address unchanged.
REQ-033 BYTES_PER_FRAME=4, send 0x01..0x04 -> writes at addresses 0..3; o_Frame_Done coincident with the write of 0x04 at address 3; the 5th byte is written at address 0.
REQ-034 Raise i_Frame_Indicator mid DATA of the 3rd byte -> that byte is dropped; the next byte is written at address 0.
REQ-035 RX_TIMEOUT_EN defined, TIMEOUT_CLKS=11935, send 2 bytes then idle 12000 cycles -> o_Timeout pulses once; the next byte is written at address 0. Undefined -> o_Timeout stays 0 and the next byte is written at address 2.
